// File: rtl/w_bus_ctrl.sv
// Registered W-bus driver: fixed-priority source select with per-source enable polarity,
// idle hold/clear policy, and contention tracking (flag, sticky error, saturating counter).
module w_bus_ctrl #(
  parameter int               WIDTH         = 8,
  parameter int               N_SRC         = 5,
  parameter logic [N_SRC-1:0] EN_ACTIVE_LOW = 5'b00110,
  parameter bit               IDLE_HOLD     = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         src_en,
  input  logic [N_SRC*WIDTH-1:0]   src_data,
  input  logic                     err_clear,
  output logic [WIDTH-1:0]         w_bus,
  output logic                     bus_valid,
  output logic [$clog2(N_SRC)-1:0] bus_owner,
  output logic                     contention,
  output logic                     contention_err,
  output logic [7:0]               contention_cnt
);

  localparam int OW = $clog2(N_SRC);
  localparam int PW = $clog2(N_SRC + 1);

  logic [N_SRC-1:0] act;
  logic [OW-1:0]    win;
  logic [PW-1:0]    pop;
  logic             any_act;

  logic [WIDTH-1:0] w_bus_q, w_bus_d;
  logic             bus_valid_q, bus_valid_d;
  logic [OW-1:0]    bus_owner_q, bus_owner_d;
  logic             contention_q, contention_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  // Scan from the top down so the lowest active index is the last assignment and wins.
  always_comb begin
    act = src_en ^ EN_ACTIVE_LOW;
    win = '0;
    pop = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (act[i]) win = OW'(i);
      pop = pop + PW'(act[i]);
    end
    any_act = |act;
  end

  always_comb begin
    w_bus_d      = w_bus_q;
    bus_valid_d  = 1'b0;
    bus_owner_d  = bus_owner_q;
    contention_d = (pop > PW'(1));
    err_d        = err_q;
    cnt_d        = cnt_q;

    if (any_act) begin
      w_bus_d     = src_data[int'(win)*WIDTH +: WIDTH];
      bus_valid_d = 1'b1;
      bus_owner_d = win;
    end else if (!IDLE_HOLD) begin
      w_bus_d = '0;
    end

    // A contention on the same edge as a clear takes precedence over the clear.
    if (contention_d) err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;

    if (err_clear) cnt_d = contention_d ? 8'd1 : 8'd0;
    else if (contention_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_bus_q      <= '0;
      bus_valid_q  <= 1'b0;
      bus_owner_q  <= '0;
      contention_q <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 8'd0;
    end else begin
      w_bus_q      <= w_bus_d;
      bus_valid_q  <= bus_valid_d;
      bus_owner_q  <= bus_owner_d;
      contention_q <= contention_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign w_bus          = w_bus_q;
  assign bus_valid      = bus_valid_q;
  assign bus_owner      = bus_owner_q;
  assign contention     = contention_q;
  assign contention_err = err_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_w_bus_ctrl.sv
// Directed bench for w_bus_ctrl: two instances (idle-hold and idle-clear) share all stimulus.
module tb_w_bus_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  src_en;
  logic [7:0]  src [5];
  logic [39:0] src_data;
  logic        err_clear;

  logic [7:0] w_bus_h, w_bus_c;
  logic       valid_h, valid_c;
  logic [2:0] owner_h, owner_c;
  logic       cont_h, cont_c;
  logic       err_h, err_c;
  logic [7:0] cnt_h, cnt_c;

  int checks = 0;
  int errors = 0;

  assign src_data = {src[4], src[3], src[2], src[1], src[0]};

  w_bus_ctrl #(.WIDTH(8), .N_SRC(5), .EN_ACTIVE_LOW(5'b00110), .IDLE_HOLD(1'b1)) dut_hold (
    .clock(clock), .reset(reset), .src_en(src_en), .src_data(src_data), .err_clear(err_clear),
    .w_bus(w_bus_h), .bus_valid(valid_h), .bus_owner(owner_h), .contention(cont_h),
    .contention_err(err_h), .contention_cnt(cnt_h)
  );

  w_bus_ctrl #(.WIDTH(8), .N_SRC(5), .EN_ACTIVE_LOW(5'b00110), .IDLE_HOLD(1'b0)) dut_clr (
    .clock(clock), .reset(reset), .src_en(src_en), .src_data(src_data), .err_clear(err_clear),
    .w_bus(w_bus_c), .bus_valid(valid_c), .bus_owner(owner_c), .contention(cont_c),
    .contention_err(err_c), .contention_cnt(cnt_c)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " w_bus"},  32'(w_bus_h), 32'h0);
    chk({tag, " valid"},  32'(valid_h), 32'h0);
    chk({tag, " owner"},  32'(owner_h), 32'h0);
    chk({tag, " cont"},   32'(cont_h),  32'h0);
    chk({tag, " err"},    32'(err_h),   32'h0);
    chk({tag, " cnt"},    32'(cnt_h),   32'h0);
    chk({tag, " w_bus_c"}, 32'(w_bus_c), 32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    err_clear = 1'b0;
    src_en    = 5'b00110;  // no source active
    for (int i = 0; i < 5; i++) src[i] = 8'h00;
    step();
    step();
    chk_all_zero("reset_init");
    reset = 1'b0;

    // 1: reset mid-stream with src3 enabled
    src[3] = 8'hA5;
    src_en = 5'b01110;
    step();
    chk("t1 load w_bus", 32'(w_bus_h), 32'hA5);
    chk("t1 load owner", 32'(owner_h), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("t1 async");
    step();
    chk_all_zero("t1 held");
    reset = 1'b0;
    src[3] = 8'h00;

    // 2: single source PC
    src[0] = 8'h0C;
    src_en = 5'b00111;
    step();
    chk("t2 w_bus", 32'(w_bus_h), 32'h0C);
    chk("t2 owner", 32'(owner_h), 32'd0);
    chk("t2 valid", 32'(valid_h), 32'd1);
    chk("t2 cont",  32'(cont_h),  32'd0);
    chk("t2 err",   32'(err_h),   32'd0);

    // 3: active-low RAM only
    src[1] = 8'h3F;
    src_en = 5'b00100;
    step();
    chk("t3 w_bus",   32'(w_bus_h), 32'h3F);
    chk("t3 owner",   32'(owner_h), 32'd1);
    chk("t3 valid",   32'(valid_h), 32'd1);
    chk("t3 w_bus_c", 32'(w_bus_c), 32'h3F);

    // 5: idle after a load of 0x55 from src4
    src[4] = 8'h55;
    src_en = 5'b10110;
    step();
    chk("t5 load w_bus", 32'(w_bus_h), 32'h55);
    chk("t5 load owner", 32'(owner_h), 32'd4);
    src_en = 5'b00110;
    step();
    chk("t5 hold w_bus",  32'(w_bus_h), 32'h55);
    chk("t5 hold valid",  32'(valid_h), 32'd0);
    chk("t5 hold owner",  32'(owner_h), 32'd4);
    chk("t5 clr w_bus",   32'(w_bus_c), 32'h00);
    chk("t5 clr valid",   32'(valid_c), 32'd0);
    chk("t5 clr owner",   32'(owner_c), 32'd4);
    chk("t5 cont",        32'(cont_h),  32'd0);

    // 4: priority + contention, then saturation
    src[0] = 8'h01;
    src[3] = 8'h80;
    src_en = 5'b01111;
    step();
    chk("t4 w_bus", 32'(w_bus_h), 32'h01);
    chk("t4 owner", 32'(owner_h), 32'd0);
    chk("t4 valid", 32'(valid_h), 32'd1);
    chk("t4 cont",  32'(cont_h),  32'd1);
    chk("t4 err",   32'(err_h),   32'd1);
    chk("t4 cnt1",  32'(cnt_h),   32'd1);
    step();
    chk("t4 cnt2",  32'(cnt_h),   32'd2);
    repeat (253) step();
    chk("t4 cnt255", 32'(cnt_h), 32'd255);
    repeat (45) step();
    chk("t4 cnt_sat", 32'(cnt_h), 32'd255);
    chk("t4 cnt_sat_c", 32'(cnt_c), 32'd255);

    // 6: clear race, then clear alone
    err_clear = 1'b1;
    step();
    chk("t6 race err", 32'(err_h), 32'd1);
    chk("t6 race cnt", 32'(cnt_h), 32'd1);
    src_en = 5'b00110;
    step();
    chk("t6 clr err",  32'(err_h),  32'd0);
    chk("t6 clr cnt",  32'(cnt_h),  32'd0);
    chk("t6 clr cont", 32'(cont_h), 32'd0);
    err_clear = 1'b0;
    src_en = 5'b00111;
    step();
    chk("t6 after err", 32'(err_h), 32'd0);
    chk("t6 after cnt", 32'(cnt_h), 32'd0);
    chk("t6 after w_bus", 32'(w_bus_h), 32'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
